icb_splt_mo: RTL
================

ICB_SPLT_MO -- requirements
Module: icb_splt_mo

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width; multiple of 8.
REQ-003 SHALL have parameter SPLT_NUM, default 4, downstream port count, >=2.
REQ-004 SHALL have parameter OSTD_NUM, default 4, outstanding-transaction depth, >=1.
REQ-005 SHALL have parameter CNT_W, default 3, outstanding-count width, >= ceil(log2(OSTD_NUM+1)).
REQ-006 SHALL have ports: clk in 1, clock; rst_n in 1, async active-low reset.
REQ-007 SHALL have ports: i_icb_splt_indic in SPLT_NUM, one-hot target select, valid with i_icb_cmd_valid.
REQ-008 SHALL have upstream cmd: i_icb_cmd_valid in 1; i_icb_cmd_ready out 1; i_icb_cmd_read in 1; i_icb_cmd_addr in AW; i_icb_cmd_wdata in DW; i_icb_cmd_wmask in DW/8.
REQ-009 SHALL have upstream rsp: i_icb_rsp_valid out 1; i_icb_rsp_ready in 1; i_icb_rsp_err out 1; i_icb_rsp_rdata out DW.
REQ-010 SHALL have downstream packed buses (port k at slice k): o_bus_icb_cmd_valid/ready/read SPLT_NUM each; o_bus_icb_cmd_addr SPLT_NUM*AW; o_bus_icb_cmd_wdata SPLT_NUM*DW; o_bus_icb_cmd_wmask SPLT_NUM*DW/8; o_bus_icb_rsp_valid/ready/err SPLT_NUM each; o_bus_icb_rsp_rdata SPLT_NUM*DW.
REQ-011 SHALL have ostd_cnt out CNT_W, current outstanding-transaction count.
REQ-012 Clocking fixed: single clock clk; rst_n asynchronous, active-low.

Function
REQ-013 Cmd fields SHALL broadcast combinationally to all ports; o_bus_icb_cmd_valid[k] = i_icb_cmd_valid & indic[k] & ~full.
REQ-014 i_icb_cmd_ready SHALL = |(indic & o_bus_icb_cmd_ready) & ~full; no combinational dependence on rsp-side signals.
REQ-015 Route-ID FIFO: OSTD_NUM entries, each holds indic (plus local-error flag when REQ-025 compiled), pushed on upstream cmd handshake, popped on upstream rsp handshake.
REQ-016 Multiple outstanding to same or different ports SHALL be permitted up to OSTD_NUM; responses returned strictly in cmd order.
REQ-017 Rsp path: head entry selects port; i_icb_rsp_valid = ~empty & rsp_valid[head]; rdata/err muxed from head port only; o_bus_icb_rsp_ready[k] = ~empty & head[k] & i_icb_rsp_ready.
REQ-018 Non-head port rsp_valid SHALL be held off (ready=0) until its entry reaches head.
REQ-019 Full: i_icb_cmd_ready=0 and all downstream cmd_valid=0, even if a pop occurs same cycle.
REQ-020 Empty: i_icb_rsp_valid=0, all rsp_ready=0; no bypass, min cmd-to-rsp latency 1 cycle.
REQ-021 Simultaneous push and pop (not full): count unchanged, pointers both advance, wrap modulo OSTD_NUM.
REQ-022 ostd_cnt SHALL increment on push only, decrement on pop only, hold on both/neither; range 0..OSTD_NUM.

Reset
REQ-023 On rst_n low, FIFO SHALL empty immediately, pointers 0, ostd_cnt 0, i_icb_rsp_valid 0, all o_bus_icb_rsp_ready 0; in-flight transactions discarded.
REQ-024 Outputs SHALL reach reset values asynchronously; release takes effect on first clk edge after rst_n high.

Configuration
REQ-025 Macro ICB_SPLT_DECERR_EN defined: indic==0 cmd SHALL be accepted locally when ~full (ready=1, no downstream valid), pushed with error flag; at head it SHALL produce i_icb_rsp_valid=1, err=1, rdata=0 without any downstream handshake.
REQ-026 Macro undefined: indic==0 cmd SHALL never be accepted (ready=0), no error flag stored.

Verification
REQ-027 Reset, then 4 back-to-back reads to port 1, slave 2-cycle latency -> all accepted, ostd_cnt peaks 4, 5th cmd stalls until first rsp pop.
REQ-028 Read port 0 then read port 2; port 2 responds first with rdata 0xBBBB -> held, upstream sees port 0 rdata 0xAAAA first, then 0xBBBB.
REQ-029 Fill to OSTD_NUM with rsp_ready=0, then cmd plus rsp pop same cycle -> cmd not accepted that cycle, accepted next.
REQ-030 DECERR_EN defined, indic=0 write addr 0x1000_0000 -> ready=1, no port valid, next cycle rsp err=1 rdata=0; undefined -> ready stays 0.
REQ-031 rst_n asserted with 3 outstanding -> ostd_cnt=0, rsp_valid=0 immediately, next cmd after release routed normally.
REQ-032 Continuous push/pop over 3*OSTD_NUM transactions -> pointer wrap, ordering and ostd_cnt correct.

Source files
------------

// File: rtl/icb_splt_mo_if.sv
// ICB 1-to-N splitter bundle: upstream cmd/rsp plus SPLT_NUM packed downstream ports (port k at slice k).
// The slave modport is the splitter's view; the master modport is the surrounding environment's view.
interface icb_splt_mo_if #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int SPLT_NUM = 4
);
    logic [SPLT_NUM-1:0]        i_icb_splt_indic;
    logic                       i_icb_cmd_valid;
    logic                       i_icb_cmd_ready;
    logic                       i_icb_cmd_read;
    logic [AW-1:0]              i_icb_cmd_addr;
    logic [DW-1:0]              i_icb_cmd_wdata;
    logic [DW/8-1:0]            i_icb_cmd_wmask;
    logic                       i_icb_rsp_valid;
    logic                       i_icb_rsp_ready;
    logic                       i_icb_rsp_err;
    logic [DW-1:0]              i_icb_rsp_rdata;

    logic [SPLT_NUM-1:0]        o_bus_icb_cmd_valid;
    logic [SPLT_NUM-1:0]        o_bus_icb_cmd_ready;
    logic [SPLT_NUM-1:0]        o_bus_icb_cmd_read;
    logic [SPLT_NUM*AW-1:0]     o_bus_icb_cmd_addr;
    logic [SPLT_NUM*DW-1:0]     o_bus_icb_cmd_wdata;
    logic [SPLT_NUM*DW/8-1:0]   o_bus_icb_cmd_wmask;
    logic [SPLT_NUM-1:0]        o_bus_icb_rsp_valid;
    logic [SPLT_NUM-1:0]        o_bus_icb_rsp_ready;
    logic [SPLT_NUM-1:0]        o_bus_icb_rsp_err;
    logic [SPLT_NUM*DW-1:0]     o_bus_icb_rsp_rdata;

    modport slave (
        input  i_icb_splt_indic, i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr,
               i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_rsp_ready,
        output i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata,
        output o_bus_icb_cmd_valid, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
               o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask, o_bus_icb_rsp_ready,
        input  o_bus_icb_cmd_ready, o_bus_icb_rsp_valid, o_bus_icb_rsp_err, o_bus_icb_rsp_rdata
    );

    modport master (
        output i_icb_splt_indic, i_icb_cmd_valid, i_icb_cmd_read, i_icb_cmd_addr,
               i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_rsp_ready,
        input  i_icb_cmd_ready, i_icb_rsp_valid, i_icb_rsp_err, i_icb_rsp_rdata,
        input  o_bus_icb_cmd_valid, o_bus_icb_cmd_read, o_bus_icb_cmd_addr,
               o_bus_icb_cmd_wdata, o_bus_icb_cmd_wmask, o_bus_icb_rsp_ready,
        output o_bus_icb_cmd_ready, o_bus_icb_rsp_valid, o_bus_icb_rsp_err, o_bus_icb_rsp_rdata
    );
endinterface

// File: rtl/icb_splt_mo.sv
// ICB splitter, multiple outstanding, in-order rsp via route-ID FIFO; cmd path combinational, rsp >=1 cycle after cmd.
// Cmd stalls when OSTD_NUM are outstanding; ICB_SPLT_DECERR_EN answers indic==0 cmds locally with err=1, rdata=0.
module icb_splt_mo #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int SPLT_NUM = 4,
    parameter int OSTD_NUM = 4,
    parameter int CNT_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    icb_splt_mo_if.slave     bus,
    output logic [CNT_W-1:0] ostd_cnt
);
    localparam int PTR_W = (OSTD_NUM > 1) ? $clog2(OSTD_NUM) : 1;

    logic [SPLT_NUM-1:0] route_q [OSTD_NUM];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                full, empty, loc_err, push, pop, head_err;
    logic [SPLT_NUM-1:0] head;
    logic                sel_vld, sel_err;
    logic [DW-1:0]       sel_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OSTD_NUM - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (cnt_q == CNT_W'(OSTD_NUM));
    assign empty = (cnt_q == '0);

`ifdef ICB_SPLT_DECERR_EN
    logic [OSTD_NUM-1:0] derr_q;
    assign loc_err  = (bus.i_icb_splt_indic == '0);
    assign head_err = ~empty & derr_q[rptr_q];
`else
    assign loc_err  = 1'b0;
    assign head_err = 1'b0;
`endif

    // Command fields fan out to every port; only the selected port sees valid.
    assign bus.o_bus_icb_cmd_read  = {SPLT_NUM{bus.i_icb_cmd_read}};
    assign bus.o_bus_icb_cmd_addr  = {SPLT_NUM{bus.i_icb_cmd_addr}};
    assign bus.o_bus_icb_cmd_wdata = {SPLT_NUM{bus.i_icb_cmd_wdata}};
    assign bus.o_bus_icb_cmd_wmask = {SPLT_NUM{bus.i_icb_cmd_wmask}};
    assign bus.o_bus_icb_cmd_valid = {SPLT_NUM{bus.i_icb_cmd_valid & ~full}} & bus.i_icb_splt_indic;
    assign bus.i_icb_cmd_ready     = ~full & ((|(bus.i_icb_splt_indic & bus.o_bus_icb_cmd_ready)) | loc_err);

    assign push = bus.i_icb_cmd_valid & bus.i_icb_cmd_ready;
    assign head = route_q[rptr_q];

    always_comb begin
        sel_vld  = 1'b0;
        sel_err  = 1'b0;
        sel_data = '0;
        for (int k = 0; k < SPLT_NUM; k++) begin
            if (head[k]) begin
                sel_vld  = sel_vld  | bus.o_bus_icb_rsp_valid[k];
                sel_err  = sel_err  | bus.o_bus_icb_rsp_err[k];
                sel_data = sel_data | bus.o_bus_icb_rsp_rdata[k*DW +: DW];
            end
        end
    end

    // Only the head port may complete; later ports are held off until they reach the head.
    assign bus.i_icb_rsp_valid     = ~empty & (sel_vld | head_err);
    assign bus.i_icb_rsp_err       = head_err | sel_err;
    assign bus.i_icb_rsp_rdata     = head_err ? '0 : sel_data;
    assign bus.o_bus_icb_rsp_ready = {SPLT_NUM{~empty & bus.i_icb_rsp_ready}} & head;

    assign pop = bus.i_icb_rsp_valid & bus.i_icb_rsp_ready;

    always_comb begin
        wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < OSTD_NUM; i++) route_q[i] <= '0;
`ifdef ICB_SPLT_DECERR_EN
            derr_q <= '0;
`endif
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            if (push) begin
                route_q[wptr_q] <= bus.i_icb_splt_indic;
`ifdef ICB_SPLT_DECERR_EN
                derr_q[wptr_q]  <= loc_err;
`endif
            end
        end
    end

    assign ostd_cnt = cnt_q;
endmodule
